// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults for the register file slice.
//   DEFAULT_DATA_WIDTH   - width of each register and data port
//   DEFAULT_ADDRESS_BITS - select width
//   DEFAULT_DEPTH        - number of registers (2**DEFAULT_ADDRESS_BITS)
package reg_file_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH   = 32;
  localparam int unsigned DEFAULT_ADDRESS_BITS = 5;
  localparam int unsigned DEFAULT_DEPTH        = 1 << DEFAULT_ADDRESS_BITS;

endpackage

// File: rtl/reg_file_read_port.sv
// reg_file_read_port: one combinational read port of the register file.
//   regs_i    - full storage array from the top
//   rd_sel_i  - register index to read
//   rd_data_o - selected contents; index 0 always reads zero
// With REG_FILE_BYPASS_EN defined, extra ports carry the current write so a
// read of the index being written returns the incoming data this cycle.
//   wr_en_i, wr_sel_i, wr_data_i - write port as seen by the storage
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDRESS_BITS = DEFAULT_ADDRESS_BITS
) (
  input  logic [DATA_WIDTH-1:0]   regs_i [1 << ADDRESS_BITS],
  input  logic [ADDRESS_BITS-1:0] rd_sel_i,
`ifdef REG_FILE_BYPASS_EN
  input  logic                    wr_en_i,
  input  logic [ADDRESS_BITS-1:0] wr_sel_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
`endif
  output logic [DATA_WIDTH-1:0]   rd_data_o
);

  always_comb begin
    rd_data_o = regs_i[rd_sel_i];
`ifdef REG_FILE_BYPASS_EN
    if (wr_en_i && (wr_sel_i == rd_sel_i)) begin
      rd_data_o = wr_data_i;
    end
`endif
    // Zero rule has final priority so forwarding can never expose index 0.
    if (rd_sel_i == '0) begin
      rd_data_o = '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// reg_file: 2**ADDRESS_BITS x DATA_WIDTH register file, one synchronous
// write port and two independent combinational read ports. Register 0 is
// hard-wired to zero. Asynchronous active-high reset clears every entry.
//   clock      - rising edge performs writes
//   reset      - asynchronous, active-high clear
//   wEn        - write enable
//   write_data - data to write
//   write_sel  - destination index (writes to 0 are discarded)
//   read_sel1  - index for read port 1
//   read_sel2  - index for read port 2
//   read_data1 - contents of register read_sel1
//   read_data2 - contents of register read_sel2
// Optional macro REG_FILE_BYPASS_EN adds write-to-read forwarding.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDRESS_BITS = DEFAULT_ADDRESS_BITS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wEn,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [ADDRESS_BITS-1:0] write_sel,
  input  logic [ADDRESS_BITS-1:0] read_sel1,
  input  logic [ADDRESS_BITS-1:0] read_sel2,
  output logic [DATA_WIDTH-1:0]   read_data1,
  output logic [DATA_WIDTH-1:0]   read_data2
);

  localparam int unsigned DEPTH = 1 << ADDRESS_BITS;

  logic [DATA_WIDTH-1:0] register_file [DEPTH];

  // Entry 0 is cleared by reset and never written, so it stays zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        register_file[i] <= '0;
      end
    end else if (wEn && (write_sel != '0)) begin
      register_file[write_sel] <= write_data;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  // Forwarding is suppressed during reset so reads stay zero while it is held.
  logic fwd_en;
  assign fwd_en = wEn & ~reset;
`endif

  reg_file_read_port #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_BITS (ADDRESS_BITS)
  ) u_read_port1 (
    .regs_i    (register_file),
    .rd_sel_i  (read_sel1),
`ifdef REG_FILE_BYPASS_EN
    .wr_en_i   (fwd_en),
    .wr_sel_i  (write_sel),
    .wr_data_i (write_data),
`endif
    .rd_data_o (read_data1)
  );

  reg_file_read_port #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_BITS (ADDRESS_BITS)
  ) u_read_port2 (
    .regs_i    (register_file),
    .rd_sel_i  (read_sel2),
`ifdef REG_FILE_BYPASS_EN
    .wr_en_i   (fwd_en),
    .wr_sel_i  (write_sel),
    .wr_data_i (write_data),
`endif
    .rd_data_o (read_data2)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: self-checking bench for reg_file (default 32 x 32 build;
// expectations follow REG_FILE_BYPASS_EN when it is defined).
`timescale 1ns/1ps
module tb_reg_file;

  localparam int unsigned DW = 32;
  localparam int unsigned AB = 5;
  localparam int unsigned N  = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          wEn;
  logic [DW-1:0] write_data;
  logic [AB-1:0] write_sel;
  logic [AB-1:0] read_sel1;
  logic [AB-1:0] read_sel2;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;

  // Reference contents of every register as the programmer sees them.
  logic [DW-1:0] model [N];

  int unsigned passed = 0;
  int unsigned total  = 0;

  reg_file #(
    .DATA_WIDTH   (DW),
    .ADDRESS_BITS (AB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wEn        (wEn),
    .write_data (write_data),
    .write_sel  (write_sel),
    .read_sel1  (read_sel1),
    .read_sel2  (read_sel2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  always #5 clock = ~clock;

  // Value a read port should present right now, given current inputs.
  function automatic logic [DW-1:0] expect_rd(input logic [AB-1:0] sel);
    if (reset) return '0;
    if (sel == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (wEn && (write_sel == sel)) return write_data;
`endif
    return model[sel];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) model[i] = '0;
  endtask

  // Advance one rising edge, applying the write rule to the model.
  task automatic cycle();
    @(posedge clock);
    if (!reset && wEn && (write_sel != 0)) model[write_sel] = write_data;
    #1;
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    reset = 1'b1; wEn = 1'b0; write_data = '0; write_sel = '0;
    read_sel1 = 5'd3; read_sel2 = 5'd17;
    model_clear();
    #1;
    total++;
    if (read_data1 !== '0 || read_data2 !== '0) begin
      $display("FAIL reset_held got rd1=%h rd2=%h exp 0/0", read_data1, read_data2);
    end else passed++;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      v = DW'(i);
      read_sel1 = v[AB-1:0];
      read_sel2 = v[AB-1:0];
      #1;
      total++;
      if (read_data1 !== '0 || read_data2 !== '0) begin
        $display("FAIL reset_clear idx=%0d got rd1=%h rd2=%h exp 0/0", i, read_data1, read_data2);
      end else passed++;
    end
  endtask

  task automatic test_write_all();
    logic [DW-1:0] v;
    logic [DW-1:0] exp;
    for (int i = 0; i < N; i++) begin
      @(negedge clock);
      v = DW'(i);
      wEn = 1'b1; write_sel = v[AB-1:0]; write_data = DW'(31 - i);
      cycle();
    end
    @(negedge clock);
    wEn = 1'b0;
    for (int i = 0; i < N; i++) begin
      v = DW'(i);
      read_sel1 = v[AB-1:0];
      read_sel2 = v[AB-1:0];
      #1;
      exp = (i == 0) ? '0 : DW'(31 - i);
      total++;
      if (read_data1 !== exp || read_data2 !== exp) begin
        $display("FAIL write_all idx=%0d got rd1=%h rd2=%h exp %h", i, read_data1, read_data2, exp);
      end else passed++;
    end
  endtask

  task automatic test_zero_index();
    @(negedge clock);
    read_sel1 = '0; read_sel2 = 5'd31;
    wEn = 1'b1; write_sel = '0; write_data = 32'd31;
    #1;
    total++;
    if (read_data1 !== '0) begin
      $display("FAIL zero_pre got %h exp 0", read_data1);
    end else passed++;
    cycle();
    total++;
    if (read_data1 !== '0) begin
      $display("FAIL zero_post got %h exp 0", read_data1);
    end else passed++;
    @(negedge clock);
    wEn = 1'b0;
  endtask

  task automatic test_read_during_write();
    logic [DW-1:0] exp_pre;
`ifdef REG_FILE_BYPASS_EN
    exp_pre = 32'hFFFF_FFFF;
`else
    exp_pre = 32'd30;
`endif
    @(negedge clock);
    wEn = 1'b1; write_sel = 5'd1; write_data = 32'hFFFF_FFFF;
    read_sel1 = 5'd1; read_sel2 = 5'd2;
    #4;
    total++;
    if (read_data1 !== exp_pre) begin
      $display("FAIL rdw_before_edge got %h exp %h", read_data1, exp_pre);
    end else passed++;
    total++;
    if (read_data2 !== 32'd29) begin
      $display("FAIL rdw_other_port got %h exp %h", read_data2, 32'd29);
    end else passed++;
    cycle();
    total++;
    if (read_data1 !== 32'hFFFF_FFFF) begin
      $display("FAIL rdw_after_edge got %h exp ffffffff", read_data1);
    end else passed++;
    @(negedge clock);
    wEn = 1'b0;
    #1;
    total++;
    if (read_data1 !== 32'hFFFF_FFFF) begin
      $display("FAIL rdw_held got %h exp ffffffff", read_data1);
    end else passed++;
  endtask

  task automatic test_wen_low();
    @(negedge clock);
    wEn = 1'b0; write_sel = 5'd5; write_data = 32'hDEAD_BEEF;
    read_sel1 = 5'd5; read_sel2 = 5'd5;
    repeat (3) cycle();
    total++;
    if (read_data1 !== 32'd26 || read_data2 !== 32'd26) begin
      $display("FAIL wen_low got rd1=%h rd2=%h exp 1a", read_data1, read_data2);
    end else passed++;
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] v;
    @(negedge clock);
    wEn = 1'b1; write_sel = 5'd7; write_data = 32'h0000_1234;
    read_sel1 = 5'd3; read_sel2 = 5'd7;
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    total++;
    if (read_data1 !== '0 || read_data2 !== '0) begin
      $display("FAIL async_reset_midcycle got rd1=%h rd2=%h exp 0/0", read_data1, read_data2);
    end else passed++;
    cycle();
    for (int i = 0; i < N; i++) begin
      v = DW'(i);
      read_sel1 = v[AB-1:0];
      read_sel2 = v[AB-1:0];
      #0.1;
      total++;
      if (read_data1 !== '0 || read_data2 !== '0) begin
        $display("FAIL async_reset_all idx=%0d got rd1=%h rd2=%h exp 0/0", i, read_data1, read_data2);
      end else passed++;
    end
    @(negedge clock);
    reset = 1'b0; wEn = 1'b0;
    read_sel1 = 5'd7; read_sel2 = 5'd7;
    #1;
    total++;
    if (read_data2 !== '0) begin
      $display("FAIL write_in_reset got %h exp 0", read_data2);
    end else passed++;
    wEn = 1'b1;
    cycle();
    @(negedge clock);
    wEn = 1'b0;
    #1;
    total++;
    if (read_data1 !== 32'h0000_1234) begin
      $display("FAIL first_write_after_reset got %h exp 00001234", read_data1);
    end else passed++;
  endtask

  task automatic test_random();
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      wEn        = ($urandom_range(0, 3) != 0);
      write_sel  = AB'($urandom_range(0, N - 1));
      write_data = $urandom;
      read_sel1  = ($urandom_range(0, 3) == 0) ? write_sel : AB'($urandom_range(0, N - 1));
      read_sel2  = ($urandom_range(0, 3) == 0) ? read_sel1 : AB'($urandom_range(0, N - 1));
      #1;
      e1 = expect_rd(read_sel1);
      e2 = expect_rd(read_sel2);
      total++;
      if (read_data1 !== e1 || read_data2 !== e2) begin
        $display("FAIL random_pre iter=%0d got rd1=%h rd2=%h exp %h/%h", k, read_data1, read_data2, e1, e2);
      end else passed++;
      cycle();
      e1 = expect_rd(read_sel1);
      e2 = expect_rd(read_sel2);
      total++;
      if (read_data1 !== e1 || read_data2 !== e2) begin
        $display("FAIL random_post iter=%0d got rd1=%h rd2=%h exp %h/%h", k, read_data1, read_data2, e1, e2);
      end else passed++;
    end
    @(negedge clock);
    wEn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_all();
    test_zero_index();
    test_read_during_write();
    test_wen_low();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each register and of the data ports.
REQ-002 Parameter ADDRESS_BITS, default 5: select width; depth is 2**ADDRESS_BITS (32) registers.
REQ-003 One clock; reset is asynchronous and active-high. Ports are named clock and reset.
REQ-004 clock  input  1  all register writes occur on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high clear of every register.
REQ-006 wEn  input  1  write enable, sampled on the rising clock edge.
REQ-007 write_data  input  DATA_WIDTH  data to write.
REQ-008 write_sel  input  ADDRESS_BITS  destination register index.
REQ-009 read_sel1  input  ADDRESS_BITS  index for read port 1.
REQ-010 read_sel2  input  ADDRESS_BITS  index for read port 2.
REQ-011 read_data1  output  DATA_WIDTH  contents of register read_sel1.
REQ-012 read_data2  output  DATA_WIDTH  contents of register read_sel2.

Function
REQ-013 Storage SHALL be an array named register_file of 2**ADDRESS_BITS entries, each DATA_WIDTH bits wide.
REQ-014 On a rising clock edge with wEn=1, reset=0 and write_sel!=0, register_file[write_sel] SHALL take the value of write_data.
REQ-015 With wEn=0, no register SHALL change.
REQ-016 Register 0 SHALL always read as 0; writes to index 0 are discarded and register_file[0] stays 0.
REQ-017 Both read ports SHALL be combinational, with zero-cycle latency and no clock dependency, and both SHALL be fully independent of each other.
REQ-018 Both ports SHALL be allowed to select the same index at the same time, and both SHALL return identical data.
REQ-019 Read-during-write to the same index, macro absent: the read port SHALL return the old value until the clock edge, and the new value from the edge onward.
REQ-020 There is one write port; there SHALL be no write-collision case.

Reset
REQ-021 While reset=1, every register_file entry SHALL be 0 immediately, independent of the clock.
REQ-022 As a result, read_data1 and read_data2 SHALL both be 0 during reset.
REQ-023 A write presented while reset=1 SHALL be ignored.
REQ-024 Deassertion of reset SHALL take effect from the first rising edge after it; the first write is accepted on that edge.

Configuration
REQ-025 Macro REG_FILE_BYPASS_EN, when defined, SHALL add write-to-read forwarding.
REQ-026 With the macro defined: when wEn=1, write_sel!=0 and read_selN==write_sel, read_dataN SHALL return write_data combinationally.
REQ-027 With the macro undefined: no forwarding; the REQ-019 behaviour applies.
REQ-028 Index 0 SHALL still read 0 in both configurations.

Structure
REQ-029 Package reg_file_pkg SHALL hold the default DATA_WIDTH and ADDRESS_BITS constants and the derived depth constant.
REQ-030 One sub-module, reg_file_read_port, SHALL be instantiated twice; it performs index decode, the zero-index rule and the optional bypass mux.
REQ-031 The storage array and the write logic SHALL stay in the top module.

Verification
REQ-032 Scenario 1: hold reset for 2 cycles, then release -> read_data1 and read_data2 = 0 for every index.
REQ-033 Scenario 2: write value 31-i to index i for i=0..31, one write per cycle, then read both ports at each index 1..31 -> both ports return 31-i; index 0 returns 0.
REQ-034 Scenario 3: after scenario 2, set read_sel1=0 -> read_data1=0, even though write_data=31 was presented to index 0.
REQ-035 Scenario 4: write_sel=1, read_sel1=1, write_data=0xFFFFFFFF, wEn=1; sample 1 time unit before the edge -> macro absent: 30 (old value); macro present: 0xFFFFFFFF. After the edge -> 0xFFFFFFFF.
REQ-036 Scenario 5: wEn=0 with write_sel=5 and write_data=0xDEADBEEF for 3 cycles -> register 5 unchanged (26).
REQ-037 Scenario 6: assert reset between clock edges mid-sequence -> all reads 0 before the next edge; a write presented during reset has no effect.
